// File: rtl/wshb_stream_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : wshb_stream_sink                                               |
// | Purpose : Wishbone responder that terminates video stream bus transfers. |
// |           Full-word DATA writes are pushed into a FIFO that is drained   |
// |           as a valid/ready pixel stream. STATUS exposes FIFO occupancy   |
// |           and a saturating count of error terminations.                  |
// | Ports   : sys_clk, sys_rst   - clock, async active-high reset            |
// |           i_cyc..i_bte       - Wishbone slave request side               |
// |           o_ack/o_err/o_rty  - registered terminations (rty tied 0)      |
// |           o_dat_sm           - registered read data                      |
// |           o_px_*, i_px_ready - downstream pixel stream                   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module wshb_stream_sink #(
  parameter int DEPTH = 16  // power of 2, >= 4
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic        i_cyc,
  input  logic        i_stb,
  input  logic        i_we,
  input  logic [31:0] i_adr,
  input  logic [31:0] i_dat_ms,
  input  logic [3:0]  i_sel,
  input  logic [2:0]  i_cti,
  input  logic [1:0]  i_bte,
  output logic        o_ack,
  output logic        o_err,
  output logic        o_rty,
  output logic [31:0] o_dat_sm,
  output logic [31:0] o_px_data,
  output logic        o_px_valid,
  input  logic        i_px_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   c_FULL    = (AW+1)'(DEPTH);
  localparam logic [AW:0]   c_CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] c_PTR_ONE = AW'(1);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_drop_cnt;
  logic          r_ack;
  logic          r_err;
  logic [31:0]   r_dat_sm;

  logic        w_req;
  logic        w_sel_status;
  logic        w_full;
  logic        w_push;
  logic        w_pop;
  logic        w_err_req;
  logic        w_stat_rd;
  logic        w_stat_wr;
  logic        w_ack_req;
  logic [4:0]  w_count5;
  logic [31:0] w_status;
  logic        w_unused;

  // Classic registered cycle: the cycle that carries ack/err never starts
  // a new request, so a held strobe yields one transfer per two cycles.
  assign w_req        = i_cyc & i_stb & ~r_ack & ~r_err;
  assign w_sel_status = i_adr[2];

  // Full is judged on the registered count; a same-cycle pop does not
  // free a slot for the push until the next cycle.
  assign w_full    = (r_count == c_FULL);
  assign w_push    = w_req & ~w_sel_status & i_we & (i_sel == 4'hF) & ~w_full;
  assign w_err_req = w_req & ~w_sel_status & (~i_we | (i_sel != 4'hF));
  assign w_stat_rd = w_req & w_sel_status & ~i_we;
  assign w_stat_wr = w_req & w_sel_status & i_we;
  // A full-word DATA write on a full FIFO falls through both ack and err:
  // that is the wait state, re-evaluated every cycle.
  assign w_ack_req = w_push | w_stat_rd | w_stat_wr;
  assign w_pop     = (r_count != '0) & i_px_ready;

  assign w_count5 = 5'(r_count);
  assign w_status = {16'h0, r_drop_cnt, 3'b000, w_count5};

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_drop_cnt <= '0;
      r_ack      <= 1'b0;
      r_err      <= 1'b0;
      r_dat_sm   <= '0;
    end else begin
      r_ack    <= w_ack_req;
      r_err    <= w_err_req;
      r_dat_sm <= w_stat_rd ? w_status : 32'h0;

      if (w_push) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_PTR_ONE;

      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_CNT_ONE;
        2'b01:   r_count <= r_count - c_CNT_ONE;
        default: r_count <= r_count;
      endcase

      if (w_stat_wr)
        r_drop_cnt <= 8'h00;
      else if (w_err_req && (r_drop_cnt != 8'hFF))
        r_drop_cnt <= r_drop_cnt + 8'd1;
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge sys_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_dat_ms;
  end

  assign o_ack      = r_ack;
  assign o_err      = r_err;
  assign o_rty      = 1'b0;
  assign o_dat_sm   = r_dat_sm;
  assign o_px_data  = r_mem[r_rd_ptr];
  assign o_px_valid = (r_count != '0);

  // Cycle/burst type and the undecoded address bits are intentionally ignored.
  assign w_unused = ^{i_cti, i_bte, i_adr[31:3], i_adr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_wshb_stream_sink.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_wshb_stream_sink                                            |
// | Purpose : Self-checking bench for wshb_stream_sink. Expected bus         |
// |           terminations and pixel words are queued as stimulus is issued  |
// |           and a negedge monitor pops and compares them.                  |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_wshb_stream_sink;

  localparam int DEPTH = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat_ms = '0;
  logic [3:0]  sel = '0;
  logic [2:0]  cti = '0;
  logic [1:0]  bte = '0;
  logic        px_ready = 1'b0;
  logic        ack, err, rty, px_valid;
  logic [31:0] dat_sm, px_data;

  wshb_stream_sink #(.DEPTH(DEPTH)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .i_cyc(cyc), .i_stb(stb), .i_we(we), .i_adr(adr), .i_dat_ms(dat_ms),
    .i_sel(sel), .i_cti(cti), .i_bte(bte),
    .o_ack(ack), .o_err(err), .o_rty(rty), .o_dat_sm(dat_sm),
    .o_px_data(px_data), .o_px_valid(px_valid), .i_px_ready(px_ready)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic        is_err;
    logic        chk_dat;
    logic [31:0] dat;
  } bexp_t;

  bexp_t       bus_q[$];
  logic [31:0] px_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  bit          streaming = 1'b0;
  int          max_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: bus terminations and pixel handshakes against the queues.
  always @(negedge sys_clk) begin
    if (!sys_rst) begin
      check("rty", {31'b0, rty}, 32'h0);
      if (ack || err) begin
        if (bus_q.size() == 0) begin
          check("unexpected_term", {30'b0, ack, err}, 32'h0);
        end else begin
          bexp_t e;
          e = bus_q.pop_front();
          check("term_kind", {30'b0, ack, err}, {30'b0, ~e.is_err, e.is_err});
          if (e.chk_dat) check("dat_sm", dat_sm, e.dat);
        end
      end
      if (px_valid && px_ready) begin
        if (px_q.size() == 0) check("unexpected_px", px_data, 32'hDEAD_DEAD);
        else check("px_data", px_data, px_q.pop_front());
      end
      if (streaming && int'(dut.r_count) > max_cnt) max_cnt = int'(dut.r_count);
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  // One Wishbone transfer; returns cycles from strobe to termination and
  // checks that the termination lasts one cycle with strobe still high.
  task automatic wb_xfer(input logic w, input logic a2, input logic [31:0] d,
                         input logic [3:0] s, input logic exp_err, input logic chk,
                         input logic [31:0] exp_dat, input int max_wait, output int lat);
    bexp_t e;
    e = '{is_err: exp_err, chk_dat: chk, dat: exp_dat};
    bus_q.push_back(e);
    cyc = 1'b1; stb = 1'b1; we = w; adr = {29'b0, a2, 2'b00}; dat_ms = d; sel = s;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!(ack || err) && lat < max_wait);
    if (!(ack || err)) begin
      n_cmp++;
      n_bad++;
      $display("FAIL term_timeout: got no ack/err, expected one within %0d cycles", max_wait);
      void'(bus_q.pop_back());
    end else begin
      tick();
      check("term_width", {30'b0, ack, err}, 32'h0);
    end
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  task automatic wr_data(input logic [31:0] d);
    int lat;
    px_q.push_back(d);
    wb_xfer(1'b1, 1'b0, d, 4'hF, 1'b0, 1'b0, 32'h0, 8, lat);
  endtask

  task automatic rd_status(input logic [31:0] exp);
    int lat;
    wb_xfer(1'b0, 1'b1, 32'h0, 4'hF, 1'b0, 1'b1, exp, 8, lat);
  endtask

  task automatic fill(input logic [31:0] base);
    for (int i = 0; i < DEPTH; i++) wr_data(base + i);
  endtask

  task automatic drain(input int n);
    px_ready = 1'b1;
    repeat (n) tick();
    px_ready = 1'b0;
    check("drained_valid", {31'b0, px_valid}, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int acks;

    // ---- reset state ----
    repeat (3) tick();
    check("rst_ack", {31'b0, ack}, 32'h0);
    check("rst_err", {31'b0, err}, 32'h0);
    check("rst_dat_sm", dat_sm, 32'h0);
    check("rst_px_valid", {31'b0, px_valid}, 32'h0);
    sys_rst = 1'b0;
    tick();

    // ---- three writes, status, then ordered drain ----
    px_q.push_back(32'h11);
    wb_xfer(1'b1, 1'b0, 32'h11, 4'hF, 1'b0, 1'b0, 32'h0, 8, lat);
    check("first_ack_latency", lat, 1);
    wr_data(32'h22);
    wr_data(32'h33);
    rd_status(32'h0000_0003);
    px_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("stream_valid", {31'b0, px_valid}, 32'h1);
      tick();
    end
    px_ready = 1'b0;
    check("empty_after_3", {31'b0, px_valid}, 32'h0);

    // ---- back-pressure on a full FIFO ----
    fill(32'h100);
    px_q.push_back(32'hAA);
    fork
      wb_xfer(1'b1, 1'b0, 32'hAA, 4'hF, 1'b0, 1'b0, 32'h0, 20, lat);
      begin
        repeat (5) begin
          tick();
          check("stall_no_ack", {31'b0, ack}, 32'h0);
        end
        px_ready = 1'b1;
        tick();
        px_ready = 1'b0;
      end
    join
    check("stall_ack_latency", lat, 7);
    rd_status(32'h0000_0010);
    drain(DEPTH);

    // ---- error terminations and drop counter ----
    wb_xfer(1'b1, 1'b0, 32'h55, 4'h3, 1'b1, 1'b0, 32'h0, 8, lat);
    wb_xfer(1'b0, 1'b0, 32'h0, 4'hF, 1'b1, 1'b1, 32'h0, 8, lat);
    check("err_no_push", {31'b0, px_valid}, 32'h0);
    rd_status(32'h0000_0200);
    wb_xfer(1'b1, 1'b1, 32'hFFFF_FFFF, 4'h0, 1'b0, 1'b0, 32'h0, 8, lat);
    rd_status(32'h0000_0000);

    // ---- continuous streaming across pointer wrap ----
    px_ready = 1'b1;
    streaming = 1'b1;
    for (int i = 0; i < 40; i++) wr_data(32'(i));
    tick();
    tick();
    streaming = 1'b0;
    px_ready = 1'b0;
    check("stream_max_count_le2", {31'b0, (max_cnt <= 2)}, 32'h1);
    check("stream_all_out", px_q.size(), 0);

    // ---- reset while a write is stalled on a full FIFO ----
    fill(32'h200);
    bus_q.push_back('{is_err: 1'b0, chk_dat: 1'b0, dat: 32'h0});
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_ms = 32'hBB; sel = 4'hF;
    repeat (3) begin
      tick();
      check("rst_stall_no_ack", {31'b0, ack}, 32'h0);
    end
    sys_rst = 1'b1;
    #1;
    check("midrst_ack", {31'b0, ack}, 32'h0);
    check("midrst_px_valid", {31'b0, px_valid}, 32'h0);
    check("midrst_count", 32'(dut.r_count), 32'h0);
    px_q.delete();
    px_q.push_back(32'hBB);
    tick();
    tick();
    sys_rst = 1'b0;
    tick();
    check("post_rst_ack", {31'b0, ack}, 32'h1);
    tick();
    check("post_rst_ack_width", {31'b0, ack}, 32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    rd_status(32'h0000_0001);
    drain(1);

    // ---- strobe dropped while stalled ----
    fill(32'h300);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h0; dat_ms = 32'hCC; sel = 4'hF;
    repeat (3) tick();
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    acks = 0;
    repeat (10) begin
      tick();
      if (ack) acks++;
    end
    check("abandon_no_ack", acks, 0);
    rd_status(32'h0000_0010);
    drain(DEPTH);

    tick();
    check("bus_q_empty", bus_q.size(), 0);
    check("px_q_empty", px_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
